acc_datapath: RTL and testbench

Parametrised accumulator datapath for the BIP processor family: holds the accumulator, extends the instruction operand, and runs a multi-operation ALU with registered status flags. It sits beside the BIP control unit and data memory, taking control strobes from the decoder and driving data memory address and write data. An optional iterative multiplier adds a multi-cycle operation with a busy handshake to the control unit.

---
 rtl/acc_dp_pkg.sv | 29 ++
 rtl/acc_dp_mul.sv | 56 +++++
 rtl/acc_datapath.sv | 136 +++++++++++++
 tb/tb_acc_datapath.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_dp_pkg.sv
// Shared encodings for the BIP accumulator datapath: ALU operations,
// accumulator source selects and status flag bit positions.
package acc_dp_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SAR = 3'd6,
    OP_MUL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    SEL_MEM  = 2'd0,
    SEL_EXT  = 2'd1,
    SEL_ALU  = 2'd2,
    SEL_HOLD = 2'd3
  } sel_a_e;

  // Bit positions inside the {Z, N, C, V} flag vector
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/acc_dp_mul.sv
// Iterative shift-add multiplier for the accumulator datapath. One partial
// product is folded in per falling edge; only the low DATA_W product bits
// are kept, which makes the result identical for signed and unsigned inputs.
module acc_dp_mul #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product_lo
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] prod;
  logic [DATA_W-1:0] partial;
  logic [CNT_W-1:0]  count;

  // Running product including this cycle's partial term; on the final
  // iteration this is the finished product handed to the accumulator.
  assign partial    = prod + (mplier[0] ? mcand : '0);
  assign product_lo = partial;
  assign done       = busy && (count == CNT_W'(1));

  // Operand capture on start, then one shift-add step per edge while busy
  always_ff @(negedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, matching real flops.
    if (!rst) begin
      busy   <= 1'b0;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
    end else if (busy) begin
      prod   <= partial;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CNT_W'(1);
      if (done) busy <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      prod   <= '0;
      count  <= CNT_W'(DATA_W);
      busy   <= 1'b1;
    end
  end

endmodule

// File: rtl/acc_datapath.sv
// BIP accumulator datapath: accumulator register, operand sign extension,
// multi-operation ALU and registered {Z, N, C, V} flags. All state changes
// on the falling clock edge. Define MUL_EN to build the iterative multiplier
// (op 7 becomes a multi-cycle multiply with o_busy); without it op 7 passes B.
module acc_datapath
  import acc_dp_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int OPERAND_W = 11,
  parameter int ADDR_W    = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPERAND_W-1:0] i_operand,
  input  logic [1:0]           i_sel_a,
  input  logic                 i_sel_b,
  input  logic [2:0]           i_alu_op,
  input  logic                 i_write_acc,
  input  logic [DATA_W-1:0]    i_mem_data,
  output logic [DATA_W-1:0]    o_mem_data,
  output logic [ADDR_W-1:0]    o_mem_address,
  output logic [3:0]           o_flags,
  output logic                 o_busy
);

  alu_op_e           alu_op;
  sel_a_e            sel_a;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] ext_operand;
  logic [DATA_W-1:0] operand_b;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W:0]   alu_wide;
  logic              alu_c;
  logic              alu_v;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;

  assign alu_op        = alu_op_e'(i_alu_op);
  assign sel_a         = sel_a_e'(i_sel_a);
  assign o_mem_data    = acc;
  assign o_mem_address = i_operand[ADDR_W-1:0];
  assign ext_operand   = {{(DATA_W - OPERAND_W){i_operand[OPERAND_W-1]}}, i_operand};
  assign operand_b     = i_sel_b ? ext_operand : i_mem_data;
  assign load_val      = (sel_a == SEL_MEM) ? i_mem_data : ext_operand;

`ifdef MUL_EN
  localparam bit MUL_BUILT = 1'b1;
  logic mul_start;

  assign mul_start = !o_busy && i_write_acc && (sel_a == SEL_ALU) && (alu_op == OP_MUL);

  acc_dp_mul #(.DATA_W(DATA_W)) u_mul (
    .clk        (clk),
    .rst        (rst),
    .start      (mul_start),
    .a          (acc),
    .b          (operand_b),
    .busy       (o_busy),
    .done       (mul_done),
    .product_lo (mul_product)
  );
`else
  localparam bit MUL_BUILT = 1'b0;

  assign o_busy      = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  // ALU result plus carry/borrow and signed overflow for the selected op
  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave a variable unassigned and infer a latch.
    alu_wide = '0;
    alu_res  = operand_b;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_wide = {1'b0, acc} + {1'b0, operand_b};
        alu_res  = alu_wide[DATA_W-1:0];
        alu_c    = alu_wide[DATA_W];
        alu_v    = (acc[DATA_W-1] == operand_b[DATA_W-1]) &&
                   (alu_res[DATA_W-1] != acc[DATA_W-1]);
      end
      OP_SUB: begin
        alu_wide = {1'b0, acc} - {1'b0, operand_b};
        alu_res  = alu_wide[DATA_W-1:0];
        alu_c    = alu_wide[DATA_W];
        alu_v    = (acc[DATA_W-1] != operand_b[DATA_W-1]) &&
                   (alu_res[DATA_W-1] != acc[DATA_W-1]);
      end
      OP_AND: alu_res = acc & operand_b;
      OP_OR:  alu_res = acc | operand_b;
      OP_XOR: alu_res = acc ^ operand_b;
      OP_SHL: begin
        alu_res = {acc[DATA_W-2:0], 1'b0};
        alu_c   = acc[DATA_W-1];
      end
      OP_SAR: begin
        alu_res = {acc[DATA_W-1], acc[DATA_W-1:1]};
        alu_c   = acc[0];
      end
      OP_MUL: alu_res = operand_b;  // PASS_B when the multiplier is absent
    endcase
  end

  // Accumulator and flag register: multiply completion first, then writes
  // accepted only while the multiplier is idle
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      o_flags <= '0;
    end else if (mul_done) begin
      acc             <= mul_product;
      o_flags[FLAG_Z] <= (mul_product == '0);
      o_flags[FLAG_N] <= mul_product[DATA_W-1];
    end else if (i_write_acc && !o_busy) begin
      case (sel_a)
        SEL_MEM, SEL_EXT: begin
          acc     <= load_val;
          o_flags <= {(load_val == '0), load_val[DATA_W-1], 1'b0, 1'b0};
        end
        SEL_ALU: begin
          if (!(MUL_BUILT && (alu_op == OP_MUL))) begin
            acc     <= alu_res;
            o_flags <= {(alu_res == '0), alu_res[DATA_W-1], alu_c, alu_v};
          end
        end
        default: ;  // SEL_HOLD keeps acc and flags
      endcase
    end
  end

endmodule

// File: tb/tb_acc_datapath.sv
// Self-checking bench for acc_datapath: directed scenarios followed by
// randomized operations checked against an arithmetic reference model.
// Build with +define+MUL_EN to exercise the multiplier variant.
module tb_acc_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] i_operand;
  logic [1:0]  i_sel_a;
  logic        i_sel_b;
  logic [2:0]  i_alu_op;
  logic        i_write_acc;
  logic [15:0] i_mem_data;
  logic [15:0] o_mem_data;
  logic [10:0] o_mem_address;
  logic [3:0]  o_flags;
  logic        o_busy;

  int errors = 0;
  int checks = 0;

  logic [15:0] acc_m;
  logic [3:0]  flags_m;  // {Z, N, C, V}

  acc_datapath #(.DATA_W(16), .OPERAND_W(11), .ADDR_W(11)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_operand     (i_operand),
    .i_sel_a       (i_sel_a),
    .i_sel_b       (i_sel_b),
    .i_alu_op      (i_alu_op),
    .i_write_acc   (i_write_acc),
    .i_mem_data    (i_mem_data),
    .o_mem_data    (o_mem_data),
    .o_mem_address (o_mem_address),
    .o_flags       (o_flags),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: integer arithmetic straight from the operation rules
  task automatic model_write(input logic [1:0] sa, input logic sb, input logic [2:0] op,
                             input logic [10:0] opnd, input logic [15:0] mem);
    logic [15:0] ext, b, r;
    int ua, ub, sa_i, sb_i, s;
    logic c, v;
    ext  = 16'($signed(opnd));
    b    = sb ? ext : mem;
    ua   = int'(acc_m);
    ub   = int'(b);
    sa_i = int'($signed(acc_m));
    sb_i = int'($signed(b));
    c = 1'b0;
    v = 1'b0;
    r = '0;
    if (sa == 2'd0 || sa == 2'd1) begin
      r       = (sa == 2'd0) ? mem : ext;
      acc_m   = r;
      flags_m = {r == 16'h0, r[15], 2'b00};
    end else if (sa == 2'd2) begin
      case (op)
        3'd0: begin
          r = 16'(ua + ub);
          c = (ua + ub) > 65535;
          s = sa_i + sb_i;
          v = (s > 32767) || (s < -32768);
        end
        3'd1: begin
          r = 16'(ua - ub);
          c = ua < ub;
          s = sa_i - sb_i;
          v = (s > 32767) || (s < -32768);
        end
        3'd2: r = acc_m & b;
        3'd3: r = acc_m | b;
        3'd4: r = acc_m ^ b;
        3'd5: begin r = 16'(ua * 2); c = ua >= 32768; end
        3'd6: begin r = 16'(sa_i >>> 1); c = (ua % 2) == 1; end
        default: r = b;
      endcase
      acc_m   = r;
      flags_m = {r == 16'h0, r[15], c, v};
    end
  endtask

  // Drive one set of controls, check the address path, clock one falling
  // edge and compare accumulator/flags/busy with the model
  task automatic step(input logic we, input logic [1:0] sa, input logic sb,
                      input logic [2:0] op, input logic [10:0] opnd,
                      input logic [15:0] mem, input string tag);
    i_write_acc = we;
    i_sel_a     = sa;
    i_sel_b     = sb;
    i_alu_op    = op;
    i_operand   = opnd;
    i_mem_data  = mem;
    #1;
    chk({tag, "/addr"}, 32'(o_mem_address), 32'(opnd));
    if (we) model_write(sa, sb, op, opnd, mem);
    @(negedge clk);
    #1;
    chk({tag, "/acc"},   32'(o_mem_data), 32'(acc_m));
    chk({tag, "/flags"}, 32'(o_flags),    32'(flags_m));
    chk({tag, "/busy"},  32'(o_busy),     32'(0));
  endtask

  initial begin
    logic [1:0]  r_sa;
    logic [2:0]  r_op;
    rst         = 1'b0;
    i_operand   = 11'h155;
    i_sel_a     = 2'd3;
    i_sel_b     = 1'b0;
    i_alu_op    = 3'd0;
    i_write_acc = 1'b0;
    i_mem_data  = 16'h0;
    acc_m       = 16'h0;
    flags_m     = 4'h0;

    #2;
    chk("reset/acc",   32'(o_mem_data),    32'h0);
    chk("reset/flags", 32'(o_flags),       32'h0);
    chk("reset/busy",  32'(o_busy),        32'h0);
    chk("reset/addr",  32'(o_mem_address), 32'h155);
    @(negedge clk);
    #2;
    rst = 1'b1;

    // Extend load of a negative operand
    step(1, 2'd1, 0, 3'd0, 11'h400, 16'h0, "ext_load");
    chk("ext_load/const", 32'({o_mem_data, o_flags}), {16'h0, 16'hFC00, 4'b0100} >> 0);

    // ADD signed overflow
    step(1, 2'd0, 0, 3'd0, 11'h000, 16'h7FFF, "load_7fff");
    step(1, 2'd2, 0, 3'd0, 11'h000, 16'h0001, "add_ovf");
    chk("add_ovf/const", 32'({o_mem_data, o_flags}), 32'({16'h8000, 4'b0101}));

    // SUB borrow
    step(1, 2'd1, 0, 3'd0, 11'h003, 16'h0, "load_3");
    step(1, 2'd2, 1, 3'd1, 11'h005, 16'h0, "sub_borrow");
    chk("sub_borrow/const", 32'({o_mem_data, o_flags}), 32'({16'hFFFE, 4'b0110}));

    // Writes with write disabled or sel_a hold must not change anything
    step(0, 2'd1, 0, 3'd0, 11'h001, 16'h0, "no_write");
    step(1, 2'd3, 0, 3'd0, 11'h001, 16'h0, "hold");

`ifdef MUL_EN
    begin
      int n;
      // acc = 0 - 3 = 0xFFFD with C=1, so C/V retention is observable
      step(1, 2'd0, 0, 3'd0, 11'h000, 16'h0000, "load_0");
      step(1, 2'd2, 1, 3'd1, 11'h003, 16'h0, "sub_3");
      chk("mul/pre", 32'({o_mem_data, o_flags}), 32'({16'hFFFD, 4'b0110}));
      i_write_acc = 1'b1;
      i_sel_a     = 2'd2;
      i_sel_b     = 1'b1;
      i_alu_op    = 3'd7;
      i_operand   = 11'h007;
      @(negedge clk);
      #1;
      i_write_acc = 1'b0;
      chk("mul/busy_rise", 32'(o_busy), 32'h1);
      n = 0;
      while (o_busy === 1'b1 && n < 40) begin
        if (n == 8) begin
          i_write_acc = 1'b1;
          i_sel_a     = 2'd0;
          i_mem_data  = 16'h5555;
        end else begin
          i_write_acc = 1'b0;
        end
        @(negedge clk);
        #1;
        n++;
        if (n == 9) chk("mul/acc_hold", 32'(o_mem_data), 32'hFFFD);
      end
      i_write_acc = 1'b0;
      chk("mul/busy_cycles", 32'(n), 32'd16);
      acc_m   = 16'(32'hFFFD * 32'd7);
      flags_m = {acc_m == 16'h0, acc_m[15], flags_m[1:0]};
      chk("mul/acc",   32'(o_mem_data), 32'hFFEB);
      chk("mul/flags", 32'(o_flags),    32'(4'b0110));
      chk("mul/model", 32'({o_mem_data, o_flags}), 32'({acc_m, flags_m}));
      // A write on the first edge after busy falls is accepted
      step(1, 2'd1, 0, 3'd0, 11'h012, 16'h0, "post_mul");
    end
`else
    step(1, 2'd0, 0, 3'd0, 11'h000, 16'h1234, "load_1234");
    step(1, 2'd2, 1, 3'd7, 11'h007, 16'h0, "pass_b");
    chk("pass_b/const", 32'({o_mem_data, o_flags}), 32'({16'h0007, 4'b0000}));
`endif

    // Randomized operations against the model
    for (int i = 0; i < 80; i++) begin
      r_sa = 2'($urandom_range(0, 3));
      r_op = 3'($urandom_range(0, 7));
`ifdef MUL_EN
      if (r_sa == 2'd2 && r_op == 3'd7) r_op = 3'd0;
`endif
      step(1'($urandom_range(0, 9) != 0), r_sa, 1'($urandom_range(0, 1)), r_op,
           11'($urandom), 16'($urandom), $sformatf("rand%0d", i));
    end

    // Asynchronous reset between clock edges
    step(1, 2'd0, 0, 3'd0, 11'h000, 16'h8421, "pre_reset");
`ifdef MUL_EN
    i_write_acc = 1'b1;
    i_sel_a     = 2'd2;
    i_sel_b     = 1'b1;
    i_alu_op    = 3'd7;
    i_operand   = 11'h003;
    @(negedge clk);
    #1;
    i_write_acc = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
    end
    chk("rst/busy_before", 32'(o_busy), 32'h1);
`endif
    #2;
    rst = 1'b0;
    #1;
    chk("rst/acc",   32'(o_mem_data), 32'h0);
    chk("rst/flags", 32'(o_flags),    32'h0);
    chk("rst/busy",  32'(o_busy),     32'h0);
    acc_m   = 16'h0;
    flags_m = 4'h0;
    @(posedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    step(1, 2'd1, 0, 3'd0, 11'h2AB, 16'h0, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
